// File: rtl/pipe_ks_subtractor.sv
// Two-stage pipelined Kogge-Stone subtractor: diff = A - B - bin (mod 2^BW).
// Computed as A + ~B + ~bin. The lower LBW bits resolve in stage 1 and their
// carry is registered; the upper slice resolves in stage 2 from that carry.

// N-bit Kogge-Stone adder with carry-in, prefix depth clog2(N).
module ks_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int LVL = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] gg;
  logic [N-1:0] pp;
  logic [N-1:0] ng;
  logic [N-1:0] np;
  logic [N:0]   carry;

  // Prefix network: gg[i]/pp[i] become group generate/propagate over bits i..0.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gg    = g;
    pp    = p;
    ng    = g;
    np    = p;
    carry = '0;
    for (int lvl = 0; lvl < LVL; lvl++) begin
      ng = gg;
      np = pp;
      for (int i = 0; i < N; i++) begin
        if (i >= (1 << lvl)) begin
          ng[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
          np[i] = pp[i] & pp[i - (1 << lvl)];
        end
      end
      gg = ng;
      pp = np;
    end
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = gg[i] | (pp[i] & cin);
    end
    sum  = p ^ carry[N-1:0];
    cout = carry[N];
  end
endmodule

module pipe_ks_subtractor #(
  parameter int BW  = 32,
  parameter int LBW = 16
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] A,
  input  logic [BW-1:0] B,
  input  logic          bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] diff,
  output logic          bout,
  output logic          ovf,
  output logic          zero
);
  localparam int UBW = BW - LBW;

  logic           s2_ready;
  logic           accept;
  logic           advance;
  logic [BW-1:0]  bn;
  logic [LBW-1:0] lo_sum;
  logic           lo_cout;
  logic [UBW-1:0] up_sum;
  logic           up_cout;
  logic [BW-1:0]  diff_full;

  logic           s1_valid_d, s1_valid_q;
  logic [LBW-1:0] s1_dlo_d,   s1_dlo_q;
  logic           s1_clo_d,   s1_clo_q;
  logic [UBW-1:0] s1_au_d,    s1_au_q;
  logic [UBW-1:0] s1_bnu_d,   s1_bnu_q;
  logic           s1_sa_d,    s1_sa_q;
  logic           s1_sb_d,    s1_sb_q;

  logic           out_valid_d, out_valid_q;
  logic [BW-1:0]  diff_d,      diff_q;
  logic           bout_d,      bout_q;
  logic           ovf_d,       ovf_q;
  logic           zero_d,      zero_q;

  assign bn = ~B;

  ks_adder #(.N(LBW)) u_lo (
    .a    (A[LBW-1:0]),
    .b    (bn[LBW-1:0]),
    .cin  (~bin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  ks_adder #(.N(UBW)) u_up (
    .a    (s1_au_q),
    .b    (s1_bnu_q),
    .cin  (s1_clo_q),
    .sum  (up_sum),
    .cout (up_cout)
  );

  assign diff_full = {up_sum, s1_dlo_q};

  // Handshake: in_ready depends only on pipeline state, never on in_valid.
  always_comb begin
    s2_ready = ~out_valid_q | out_ready;
    in_ready = ~s1_valid_q | s2_ready;
    accept   = in_valid & in_ready;
    advance  = s1_valid_q & s2_ready;
  end

  // Next-state for both stages: stage 1 loads on accept, stage 2 on advance.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_dlo_d    = s1_dlo_q;
    s1_clo_d    = s1_clo_q;
    s1_au_d     = s1_au_q;
    s1_bnu_d    = s1_bnu_q;
    s1_sa_d     = s1_sa_q;
    s1_sb_d     = s1_sb_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_dlo_d   = lo_sum;
      s1_clo_d   = lo_cout;
      s1_au_d    = A[BW-1:LBW];
      s1_bnu_d   = bn[BW-1:LBW];
      s1_sa_d    = A[BW-1];
      s1_sb_d    = B[BW-1];
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end

    if (advance) begin
      out_valid_d = 1'b1;
      diff_d      = diff_full;
      bout_d      = ~up_cout;
      ovf_d       = (s1_sa_q != s1_sb_q) & (diff_full[BW-1] != s1_sa_q);
      zero_d      = ~|diff_full;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and result registers; async clear discards all in-flight ops.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  // Stage-1 operand/partial-result registers; qualified by s1_valid_q only.
  always_ff @(posedge CLK) begin
    s1_dlo_q <= s1_dlo_d;
    s1_clo_q <= s1_clo_d;
    s1_au_q  <= s1_au_d;
    s1_bnu_q <= s1_bnu_d;
    s1_sa_q  <= s1_sa_d;
    s1_sb_q  <= s1_sb_d;
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule
